cpu16_mem_responder: RTL and testbench
======================================

// Module: cpu16_mem_responder
// PURPOSE
//  Bus-side responder for the CPU16 master: single-port word RAM window answering CPU16
//  address/data_out/write with 1-cycle registered read data (matches CPU16 RAM_WAIT=1).
//  Owns the CPU16 hold line: an external program loader requests the bus, the block parks
//  the CPU via hold/busy, then streams words into RAM. Flags out-of-window writes.
// PARAMETERS
//  AW        12        RAM address width; window = 2**AW words
//  BASE      16'h4000  window base (CPU16 reset IP); must be aligned to 2**AW
//  INIT_FILE ""        optional $readmemh image; "" = no init
// PORTS
//  clk          in   1   clock; all logic on posedge
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  cpu_address  in   16  CPU16 address
//  cpu_wdata    in   16  CPU16 data_out
//  cpu_write    in   1   CPU16 write strobe (high one cycle per store)
//  cpu_rdata    out  16  to CPU16 data_in
//  cpu_hold     out  1   to CPU16 hold
//  cpu_busy     in   1   from CPU16 busy (1 = parked in select)
//  ld_req       in   1   loader wants bus; held high for whole session
//  ld_valid     in   1   loader word valid
//  ld_addr      in   AW  loader word address (window offset)
//  ld_data      in   16  loader word
//  ld_ready     out  1   loader word accepted when ld_valid&&ld_ready
//  ld_count     out  16  words written this session
//  err          out  1   sticky bus error
//  err_addr     out  16  address of first error since last clear
//  err_clr      in   1   clears err
// BEHAVIOUR
//  Reset (reset==0 at edge): cpu_rdata=0, cpu_hold=0, ld_ready=0, ld_count=0, err=0,
//   err_addr=0, FSM=IDLE. RAM contents NOT cleared. Reset mid-session aborts it identically.
//  hit = cpu_address[15:AW]==BASE[15:AW]; off = cpu_address[AW-1:0].
//  Read: every edge cpu_rdata <= hit ? mem[off] : 16'h0000. Latency 1 from address.
//   Read-during-write same word returns OLD data (read-first).
//  CPU write: cpu_write&&hit&&FSM!=GRANT -> mem[off]<=cpu_wdata.
//   cpu_write&&!hit -> no RAM write, error event with cpu_address.
//   cpu_write in GRANT (protocol violation) -> dropped, error event with cpu_address.
//  Error event: if err==0 capture err_addr; err<=1. Event and err_clr same cycle -> err=1,
//   err_addr = new address. err_clr alone -> err<=0, err_addr held.
//  Loader FSM (2-bit):
//   IDLE:    hold=0, ready=0. ld_req -> REQ, ld_count<=0.
//   REQ:     hold=1, ready=0. !ld_req -> IDLE; cpu_busy&&!cpu_write -> GRANT.
//   GRANT:   hold=1, ready=1. ld_valid -> mem[ld_addr]<=ld_data, ld_count++ (wraps at
//            16'hFFFF->0). !ld_req -> RELEASE (ld_valid with !ld_req ignored).
//   RELEASE: hold=0, ready=0, one cycle -> IDLE. ld_req during RELEASE ignored.
//   cpu_hold, ld_ready are registered FSM decodes (valid the cycle the state is entered).
//  Busy after reset: CPU16 holds busy=1 until first select; REQ may grant immediately.
//  Exactly one RAM write per cycle; loader and CPU writes never coincide by construction.
// STRUCTURE
//  Shared header cpu16_bus.vh: FSM state localparams (LD_IDLE/REQ/GRANT/RELEASE),
//   default BASE 16'h4000, error-code constants.
//  Sub-module cpu16_ram_1r1w #(AW,INIT_FILE): sync RAM, registered read-first port,
//   one write port; top muxes write port between CPU and loader by FSM state.
//  Top holds decode, error logic, loader FSM, ld_count.
// TESTING
//  1 reset=0 3 cycles mid-random traffic -> hold=0, ld_ready=0, err=0, cpu_rdata=0.
//  2 write 0x4005<-0xBEEF, then address 0x4005 -> cpu_rdata=0xBEEF one edge later;
//    address 0x4006 unwritten with INIT_FILE="" -> no X propagation checked vs model.
//  3 write 0x0010<-0x1234 -> err=1, err_addr=0x0010, window unchanged; read 0x0010 ->
//    0x0000; second miss 0x0020 -> err_addr stays 0x0010; err_clr -> err=0.
//  4 ld_req=1 with cpu_busy=0 -> hold=1, ld_ready=0 until cpu_busy=1; load 0x11,0x22,
//    0x33,0x44 to offsets 0..3 -> ld_count=4; drop ld_req -> hold=0 after RELEASE;
//    read 0x4002 -> 0x0033.
//  5 reset=0 during GRANT after 2 words -> next edge hold=0, ld_ready=0, ld_count=0;
//    both loaded words still readable.
//  6 cpu_write to 0x0000 coincident with err_clr while err=1 -> err=1, err_addr=0x0000.

Source files
------------

// File: rtl/cpu16_mem_responder_pkg.sv
// Purpose: shared types, constants and helpers for the CPU16 memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu16_mem_responder_pkg;

    // Window base used when the integrator does not override it (CPU16 reset IP).
    localparam logic [15:0] DEFAULT_BASE = 16'h4000;

    // Loader arbitration states; encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_REQ     = 2'd1,
        LD_GRANT   = 2'd2,
        LD_RELEASE = 2'd3
    } ld_state_t;

    // One bus error event: qualifier plus the offending CPU address.
    typedef struct packed {
        logic        vld;
        logic [15:0] addr;
    } err_evt_t;

    // True when addr falls inside the 2**aw word window that starts at base.
    function automatic logic win_hit(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int unsigned aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/cpu16_mem_responder_ram.sv
// Purpose: single-clock word RAM, one write port and one registered read-first read port.
// Latency: read data valid one edge after raddr; a same-word write returns the old word.
// Backpressure: none; accepts one write and one read every cycle.
module cpu16_mem_responder_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [15:0] mem [DEPTH];

    // Storage is deliberately not reset: a reset must not lose a loaded program.
    // The read samples the array before this edge's write lands, giving read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cpu16_mem_responder.sv
// Purpose: CPU16 RAM window responder with loader bus takeover and sticky miss error.
// Latency: cpu_rdata one edge after cpu_address; loader word written on the accepting edge.
// Backpressure: ld_ready high only while the CPU is parked (GRANT); CPU is stalled via cpu_hold.
module cpu16_mem_responder
    import cpu16_mem_responder_pkg::*;
#(
    parameter int unsigned AW   = 12,
    parameter logic [15:0] BASE = DEFAULT_BASE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   cpu_address,
    input  logic [15:0]   cpu_wdata,
    input  logic          cpu_write,
    output logic [15:0]   cpu_rdata,
    output logic          cpu_hold,
    input  logic          cpu_busy,
    input  logic          ld_req,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    output logic          ld_ready,
    output logic [15:0]   ld_count,
    output logic          err,
    output logic [15:0]   err_addr,
    input  logic          err_clr
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          hit;
    logic [AW-1:0] off;

    assign hit = win_hit(cpu_address, BASE, AW);
    assign off = cpu_address[AW-1:0];

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    ld_state_t state;
    ld_state_t state_nxt;
    logic      hold_nxt;
    logic      ready_nxt;

    // Next-state logic; hold/ready are decoded from the next state so the
    // registered outputs are already correct in the cycle a state is entered.
    always_comb begin
        state_nxt = state;
        hold_nxt  = 1'b0;
        ready_nxt = 1'b0;
        case (state)
            LD_IDLE: begin
                if (ld_req) begin
                    state_nxt = LD_REQ;
                end
            end
            LD_REQ: begin
                // A withdrawn request wins over a grant; a store in flight
                // from the CPU delays the grant by at least one cycle.
                if (!ld_req) begin
                    state_nxt = LD_IDLE;
                end else if (cpu_busy && !cpu_write) begin
                    state_nxt = LD_GRANT;
                end
            end
            LD_GRANT: begin
                if (!ld_req) begin
                    state_nxt = LD_RELEASE;
                end
            end
            LD_RELEASE: begin
                // One dead cycle so the CPU sees hold drop before any new request.
                state_nxt = LD_IDLE;
            end
            default: begin
                state_nxt = LD_IDLE;
            end
        endcase
        hold_nxt  = (state_nxt == LD_REQ) || (state_nxt == LD_GRANT);
        ready_nxt = (state_nxt == LD_GRANT);
    end

    // State register with registered hold/ready decodes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= LD_IDLE;
            cpu_hold <= 1'b0;
            ld_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            cpu_hold <= hold_nxt;
            ld_ready <= ready_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write arbitration: the loader owns the port only in GRANT, where any
    // CPU store is a protocol violation and is dropped.
    // ------------------------------------------------------------------
    logic          in_grant;
    logic          ld_wr;
    logic          cpu_wr;
    err_evt_t      err_evt;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic          hit_q;

    assign in_grant     = (state == LD_GRANT);
    assign ld_wr        = in_grant && ld_valid && ld_req;
    assign cpu_wr       = cpu_write && hit && !in_grant;
    assign err_evt.vld  = cpu_write && (!hit || in_grant);
    assign err_evt.addr = cpu_address;

    // Select the single RAM write source for this cycle.
    always_comb begin
        ram_we    = cpu_wr;
        ram_waddr = off;
        ram_wdata = cpu_wdata;
        if (in_grant) begin
            ram_we    = ld_wr;
            ram_waddr = ld_addr;
            ram_wdata = ld_data;
        end
    end

    cpu16_mem_responder_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (off),
        .rdata (ram_rdata)
    );

    // Remember whether the address just read was in the window so misses
    // return zero; clearing it on reset forces cpu_rdata to zero as well.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit;
        end
    end

    assign cpu_rdata = hit_q ? ram_rdata : 16'h0000;

    // ------------------------------------------------------------------
    // Session word counter
    // ------------------------------------------------------------------

    // Cleared when a new session is requested; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_count <= 16'h0000;
        end else if ((state == LD_IDLE) && ld_req) begin
            ld_count <= 16'h0000;
        end else if (ld_wr) begin
            ld_count <= ld_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error
    // ------------------------------------------------------------------

    // A new event beats a simultaneous clear and then reports its own address;
    // otherwise only the first event after a clear is captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err      <= 1'b0;
            err_addr <= 16'h0000;
        end else if (err_evt.vld) begin
            err <= 1'b1;
            if (!err || err_clr) begin
                err_addr <= err_evt.addr;
            end
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu16_mem_responder.sv
// Purpose: directed scoreboard bench for cpu16_mem_responder.
// Latency: expectations are pushed when inputs are driven and checked 1 ns after the next edge.
// Backpressure: loader is driven only while ld_ready is expected high.
module tb_cpu16_mem_responder;

    localparam int AW = 12;

    localparam int K_RDATA   = 0;
    localparam int K_HOLD    = 1;
    localparam int K_READY   = 2;
    localparam int K_ERR     = 3;
    localparam int K_ERRADDR = 4;
    localparam int K_COUNT   = 5;
    localparam int K_NOX     = 6;

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [15:0]   cpu_address;
    logic [15:0]   cpu_wdata;
    logic          cpu_write;
    logic [15:0]   cpu_rdata;
    logic          cpu_hold;
    logic          cpu_busy;
    logic          ld_req;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic          ld_ready;
    logic [15:0]   ld_count;
    logic          err;
    logic [15:0]   err_addr;
    logic          err_clr;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_bad;
    logic [15:0] mdl [1 << AW];
    bit          wrt [1 << AW];

    cpu16_mem_responder #(
        .AW   (AW),
        .BASE (16'h4000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_write   (cpu_write),
        .cpu_rdata   (cpu_rdata),
        .cpu_hold    (cpu_hold),
        .cpu_busy    (cpu_busy),
        .ld_req      (ld_req),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_count    (ld_count),
        .err         (err),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: after each edge, compare every expectation queued before it.
    always @(posedge clk) begin : monitor
        exp_t        e;
        logic [15:0] act;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = 16'h0000;
            case (e.kind)
                K_RDATA:   act = cpu_rdata;
                K_HOLD:    act = {15'd0, cpu_hold};
                K_READY:   act = {15'd0, ld_ready};
                K_ERR:     act = {15'd0, err};
                K_ERRADDR: act = err_addr;
                K_COUNT:   act = ld_count;
                default:   act = {15'd0, $isunknown(cpu_rdata)};
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h required %h (t=%0t)", e.name, act, e.val, $time);
            end
        end
    end

    function automatic bit in_win(input logic [15:0] a);
        return a[15:12] == 4'h4;
    endfunction

    task automatic expect_v(input int k, input logic [15:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Queue the read result the model predicts for address a (before any write this cycle).
    task automatic expect_read(input logic [15:0] a, input string n);
        logic [AW-1:0] o;
        o = a[AW-1:0];
        if (!in_win(a))    expect_v(K_RDATA, 16'h0000, n);
        else if (wrt[o])   expect_v(K_RDATA, mdl[o], n);
        else               expect_v(K_NOX, 16'h0000, n);
    endtask

    task automatic cpu_rd(input logic [15:0] a, input string n);
        @(negedge clk);
        cpu_address = a;
        cpu_write   = 1'b0;
        ld_valid    = 1'b0;
        expect_read(a, n);
    endtask

    // CPU store; commit=0 means the store is expected to be dropped.
    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d, input bit commit, input string n);
        @(negedge clk);
        cpu_address = a;
        cpu_wdata   = d;
        cpu_write   = 1'b1;
        ld_valid    = 1'b0;
        expect_read(a, n);
        if (commit && in_win(a)) begin
            mdl[a[AW-1:0]] = d;
            wrt[a[AW-1:0]] = 1'b1;
        end
    endtask

    task automatic ld_word(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_write = 1'b0;
        ld_valid  = 1'b1;
        ld_addr   = a;
        ld_data   = d;
        mdl[a]    = d;
        wrt[a]    = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        cpu_address = 16'h0000;
        cpu_wdata   = 16'h0000;
        cpu_write   = 1'b0;
        cpu_busy    = 1'b0;
        ld_req      = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = 16'h0000;
        err_clr     = 1'b0;

        // 1: reset held three cycles under random miss traffic
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_address = 16'($urandom_range(0, 16'h3FFF));
            cpu_wdata   = 16'($urandom);
            cpu_write   = 1'($urandom_range(0, 1));
            cpu_busy    = 1'($urandom_range(0, 1));
            ld_req      = 1'($urandom_range(0, 1));
            ld_valid    = 1'($urandom_range(0, 1));
            err_clr     = 1'($urandom_range(0, 1));
            if (i == 2) begin
                expect_v(K_HOLD,    16'h0000, "rst_hold");
                expect_v(K_READY,   16'h0000, "rst_ready");
                expect_v(K_ERR,     16'h0000, "rst_err");
                expect_v(K_ERRADDR, 16'h0000, "rst_err_addr");
                expect_v(K_RDATA,   16'h0000, "rst_rdata");
                expect_v(K_COUNT,   16'h0000, "rst_count");
            end
        end
        @(negedge clk);
        reset     = 1'b1;
        cpu_write = 1'b0;
        cpu_busy  = 1'b0;
        ld_req    = 1'b0;
        ld_valid  = 1'b0;
        err_clr   = 1'b0;
        cpu_address = 16'h3000;

        // 2: window writes and reads, read-first, window edges
        cpu_wr(16'h4005, 16'hBEEF, 1'b1, "wr_4005_old");
        cpu_rd(16'h4005, "rd_4005_beef");
        cpu_rd(16'h4006, "rd_4006_nox");
        cpu_wr(16'h4005, 16'h1111, 1'b1, "rdw_4005_old_beef");
        cpu_rd(16'h4005, "rd_4005_1111");
        cpu_wr(16'h4010, 16'h7777, 1'b1, "wr_4010");
        cpu_wr(16'h4FFF, 16'hA5A5, 1'b1, "wr_4fff");
        cpu_rd(16'h4FFF, "rd_4fff_top");
        cpu_rd(16'h5000, "rd_5000_miss");
        cpu_rd(16'h3FFF, "rd_3fff_miss");
        expect_v(K_ERR, 16'h0000, "no_err_after_hits");

        // 3: out-of-window store and sticky error
        cpu_wr(16'h0010, 16'h1234, 1'b0, "wr_0010_rd");
        expect_v(K_ERR,     16'h0001, "miss_err_set");
        expect_v(K_ERRADDR, 16'h0010, "miss_err_addr");
        cpu_rd(16'h0010, "rd_0010_zero");
        cpu_rd(16'h4010, "rd_4010_unchanged");
        cpu_wr(16'h0020, 16'h5678, 1'b0, "wr_0020_rd");
        expect_v(K_ERRADDR, 16'h0010, "second_miss_addr_held");
        @(negedge clk);
        cpu_write = 1'b0;
        err_clr   = 1'b1;
        expect_v(K_ERR,     16'h0000, "clr_err");
        expect_v(K_ERRADDR, 16'h0010, "clr_addr_held");
        @(negedge clk);
        err_clr = 1'b0;

        // 4: loader session
        @(negedge clk);
        ld_req = 1'b1; cpu_busy = 1'b0; cpu_address = 16'h4000;
        expect_v(K_HOLD,  16'h0001, "req_hold");
        expect_v(K_READY, 16'h0000, "req_not_ready");
        expect_v(K_COUNT, 16'h0000, "req_count_clr");
        @(negedge clk);
        expect_v(K_HOLD,  16'h0001, "req_wait_hold");
        expect_v(K_READY, 16'h0000, "req_wait_not_ready");
        @(negedge clk);
        cpu_busy = 1'b1; cpu_write = 1'b1; cpu_address = 16'h4100; cpu_wdata = 16'h5555;
        mdl[12'h100] = 16'h5555; wrt[12'h100] = 1'b1;
        expect_v(K_READY, 16'h0000, "req_store_blocks_grant");
        @(negedge clk);
        cpu_write = 1'b0;
        expect_v(K_HOLD,  16'h0001, "grant_hold");
        expect_v(K_READY, 16'h0001, "grant_ready");
        ld_word(12'd0, 16'h0011);
        expect_v(K_COUNT, 16'h0001, "count_1");
        ld_word(12'd1, 16'h0022);
        ld_word(12'd2, 16'h0033);
        ld_word(12'd3, 16'h0044);
        expect_v(K_COUNT, 16'h0004, "count_4");
        cpu_wr(16'h4003, 16'hDEAD, 1'b0, "grant_store_rd");
        expect_v(K_ERR,     16'h0001, "grant_store_err");
        expect_v(K_ERRADDR, 16'h4003, "grant_store_err_addr");
        expect_v(K_COUNT,   16'h0004, "grant_store_no_count");
        @(negedge clk);
        cpu_write = 1'b0; err_clr = 1'b1;
        expect_v(K_ERR, 16'h0000, "grant_err_clr");
        @(negedge clk);
        err_clr = 1'b0; ld_req = 1'b0;
        expect_v(K_HOLD,  16'h0000, "release_hold");
        expect_v(K_READY, 16'h0000, "release_ready");
        expect_v(K_COUNT, 16'h0004, "release_count");
        @(negedge clk);
        ld_req = 1'b1; cpu_busy = 1'b0;
        expect_v(K_HOLD,  16'h0000, "release_ignores_req");
        expect_v(K_COUNT, 16'h0004, "idle_count_kept");
        @(negedge clk);
        expect_v(K_HOLD,  16'h0001, "rereq_hold");
        expect_v(K_COUNT, 16'h0000, "rereq_count_clr");
        @(negedge clk);
        ld_req = 1'b0;
        expect_v(K_HOLD, 16'h0000, "withdraw_hold");
        cpu_rd(16'h4002, "rd_4002_0033");
        cpu_rd(16'h4003, "rd_4003_0044");
        cpu_rd(16'h4100, "rd_4100_5555");

        // 5: reset during GRANT
        @(negedge clk);
        ld_req = 1'b1; cpu_busy = 1'b1;
        expect_v(K_HOLD, 16'h0001, "s5_req_hold");
        @(negedge clk);
        expect_v(K_READY, 16'h0001, "s5_grant_ready");
        ld_word(12'h020, 16'hAAAA);
        ld_word(12'h021, 16'hBBBB);
        expect_v(K_COUNT, 16'h0002, "s5_count_2");
        @(negedge clk);
        ld_valid = 1'b0; reset = 1'b0;
        expect_v(K_HOLD,  16'h0000, "s5_rst_hold");
        expect_v(K_READY, 16'h0000, "s5_rst_ready");
        expect_v(K_COUNT, 16'h0000, "s5_rst_count");
        @(negedge clk);
        reset = 1'b1; ld_req = 1'b0; cpu_busy = 1'b0;
        expect_v(K_HOLD, 16'h0000, "s5_after_hold");
        cpu_rd(16'h4020, "rd_4020_aaaa");
        cpu_rd(16'h4021, "rd_4021_bbbb");

        // 6: error event coincident with clear
        cpu_wr(16'h0030, 16'h0001, 1'b0, "wr_0030_rd");
        expect_v(K_ERR,     16'h0001, "s6_err_set");
        expect_v(K_ERRADDR, 16'h0030, "s6_err_addr_0030");
        @(negedge clk);
        cpu_address = 16'h0000; cpu_write = 1'b1; err_clr = 1'b1;
        expect_v(K_ERR,     16'h0001, "evt_clr_err");
        expect_v(K_ERRADDR, 16'h0000, "evt_clr_addr");
        @(negedge clk);
        cpu_write = 1'b0;
        expect_v(K_ERR,     16'h0000, "clr_only_err");
        expect_v(K_ERRADDR, 16'h0000, "clr_only_addr");
        @(negedge clk);
        err_clr = 1'b0;

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
